// File: rtl/ls_ctrl_pkg.sv
// Shared control definitions for the load/store microsequencer and the
// instruction encoder: state codes, entry-code window, datapath select
// encodings and the load/store attribute decode.
package ls_ctrl_pkg;

  localparam int STATE_W = 10;

  // Encoder entry codes for load/store instructions occupy [16, 47].
  localparam logic [STATE_W-1:0] ENTRY_BASE  = STATE_W'(16);
  localparam logic [STATE_W-1:0] ENTRY_LIMIT = STATE_W'(47);

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = STATE_W'(0),
    ST_FETCH0 = STATE_W'(1),
    ST_FETCH1 = STATE_W'(2),
    ST_PCINC  = STATE_W'(3),
    ST_DECODE = STATE_W'(4),
    ST_ADDR   = STATE_W'(5),
    ST_STDATA = STATE_W'(6),
    ST_MEM    = STATE_W'(7),
    ST_LDWB   = STATE_W'(8),
    ST_RNWB   = STATE_W'(9)
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_PASS_A = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RN  = 2'd0,
    A_PC  = 2'd1,
    A_MDR = 2'd2,
    A_RD  = 2'd3
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    B_IMM12 = 2'd0,
    B_RM    = 2'd1,
    B_FOUR  = 2'd2
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    MODE_IMM_OFFSET = 2'd0,
    MODE_IMM_PRE    = 2'd1,
    MODE_IMM_POST   = 2'd2,
    MODE_REG_OFFSET = 2'd3
  } mode_t;

  // Field order matches f = code - 16: {L, B, U, mode[1:0]}.
  typedef struct packed {
    logic  l;
    logic  b;
    logic  u;
    mode_t mode;
  } attr_t;

  function automatic logic entry_valid(input logic [STATE_W-1:0] code);
    return (code >= ENTRY_BASE) && (code <= ENTRY_LIMIT);
  endfunction

  // Only the low five bits of (code - 16) matter, and those equal the low
  // five bits of the code minus 16 modulo 32.
  function automatic attr_t entry_attr(input logic [STATE_W-1:0] code);
    return attr_t'(code[4:0] - 5'd16);
  endfunction

  // Pre- and post-indexed modes write the computed address back to Rn.
  function automatic logic needs_rn_wb(input mode_t mode);
    return (mode == MODE_IMM_PRE) || (mode == MODE_IMM_POST);
  endfunction

endpackage

// File: rtl/ls_microsequencer_moc_timer.sv
// MOC wait timer. Counts cycles spent waiting for memory completion.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : hold the count at zero (asserted outside wait states)
//   inc        : advance the count by one this cycle
//   expired    : count has reached TIMEOUT-1
module moc_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ls_microsequencer.sv
// Load/store control-unit sequencer: fetch, decode and load/store execute.
// Outputs are decoded from the registered state; ir_ld and the load-path
// mdr_ld are further qualified by moc.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   entry_state    : encoder entry code, sampled in DECODE
//   moc            : memory operation complete
//   state_out      : current state code
//   *_ld           : register load strobes (MAR, MDR, IR, PC, register file)
//   mdr_src        : 0 = ALU, 1 = memory
//   rf_dst         : 0 = Rd, 1 = Rn
//   alu_a_sel/b_sel/alu_op : ALU operand and operation selects
//   mfa, mem_rw, mem_byte  : memory request, 1 = read, 1 = byte
//   illegal        : pulse on an unsupported entry code
//   mem_fault      : pulse on MOC timeout
module ls_microsequencer
  import ls_ctrl_pkg::*;
#(
  parameter int MOC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] entry_state,
  input  logic               moc,
  output logic [STATE_W-1:0] state_out,
  output logic               mar_ld,
  output logic               mdr_ld,
  output logic               ir_ld,
  output logic               pc_ld,
  output logic               rf_ld,
  output logic               mdr_src,
  output logic               rf_dst,
  output logic [1:0]         alu_a_sel,
  output logic [1:0]         alu_b_sel,
  output logic [1:0]         alu_op,
  output logic               mfa,
  output logic               mem_rw,
  output logic               mem_byte,
  output logic               illegal,
  output logic               mem_fault
);

  state_t state, state_nxt;
  attr_t  attr;
  logic   waiting;
  logic   expired;
  logic   timed_out;

  assign waiting   = (state == ST_FETCH1) || (state == ST_MEM);
  assign timed_out = waiting && expired && !moc;

  moc_timer #(.TIMEOUT(MOC_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting),
    .inc     (waiting && !moc),
    .expired (expired)
  );

  // Attribute register is cleared on reset so outputs never depend on a
  // stale decode from before the reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
      attr  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE && entry_valid(entry_state)) begin
        attr <= entry_attr(entry_state);
      end
    end
  end

  // NOTE: every output and next-state value gets a default first, so no
  // path through the case leaves a signal unassigned (no inferred latch).
  always_comb begin
    state_nxt = state;
    mar_ld    = 1'b0;
    mdr_ld    = 1'b0;
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    rf_ld     = 1'b0;
    mdr_src   = 1'b0;
    rf_dst    = 1'b0;
    alu_a_sel = A_RN;
    alu_b_sel = B_IMM12;
    alu_op    = ALU_ADD;
    mfa       = 1'b0;
    mem_rw    = 1'b0;
    mem_byte  = 1'b0;
    illegal   = 1'b0;
    mem_fault = 1'b0;

    case (state)
      ST_RESET: state_nxt = ST_FETCH0;
      ST_FETCH0: begin
        mar_ld    = 1'b1;
        alu_a_sel = A_PC;
        alu_op    = ALU_PASS_A;
        state_nxt = ST_FETCH1;
      end
      ST_FETCH1: begin
        mfa    = 1'b1;
        mem_rw = 1'b1;
        ir_ld  = moc;
        if (moc) begin
          state_nxt = ST_PCINC;
        end else if (timed_out) begin
          mem_fault = 1'b1;
          state_nxt = ST_FETCH0;
        end
      end
      ST_PCINC: begin
        pc_ld     = 1'b1;
        alu_a_sel = A_PC;
        alu_b_sel = B_FOUR;
        alu_op    = ALU_ADD;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (entry_valid(entry_state)) begin
          state_nxt = ST_ADDR;
        end else begin
          illegal   = 1'b1;
          state_nxt = ST_FETCH0;
        end
      end
      ST_ADDR: begin
        mar_ld    = 1'b1;
        alu_a_sel = A_RN;
        alu_b_sel = (attr.mode == MODE_REG_OFFSET) ? B_RM : B_IMM12;
        if (attr.mode == MODE_IMM_POST) begin
          alu_op = ALU_PASS_A;
        end else begin
          alu_op = attr.u ? ALU_ADD : ALU_SUB;
        end
        state_nxt = attr.l ? ST_MEM : ST_STDATA;
      end
      ST_STDATA: begin
        mdr_ld    = 1'b1;
        alu_a_sel = A_RD;
        alu_op    = ALU_PASS_A;
        state_nxt = ST_MEM;
      end
      ST_MEM: begin
        mfa      = 1'b1;
        mem_rw   = attr.l;
        mem_byte = attr.b;
        if (attr.l) begin
          mdr_ld  = moc;
          mdr_src = 1'b1;
        end
        if (moc) begin
          if (attr.l)                       state_nxt = ST_LDWB;
          else if (needs_rn_wb(attr.mode))  state_nxt = ST_RNWB;
          else                              state_nxt = ST_FETCH0;
        end else if (timed_out) begin
          mem_fault = 1'b1;
          state_nxt = ST_FETCH0;
        end
      end
      ST_LDWB: begin
        rf_ld     = 1'b1;
        alu_a_sel = A_MDR;
        alu_op    = ALU_PASS_A;
        state_nxt = needs_rn_wb(attr.mode) ? ST_RNWB : ST_FETCH0;
      end
      // Runs after LDWB, so Rn's update overrides Rd's when they alias.
      ST_RNWB: begin
        rf_ld     = 1'b1;
        rf_dst    = 1'b1;
        alu_a_sel = A_RN;
        alu_b_sel = B_IMM12;
        alu_op    = attr.u ? ALU_ADD : ALU_SUB;
        state_nxt = ST_FETCH0;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  assign state_out = state;

endmodule
